// File: rtl/fetch_ctrl.sv
// fetch_ctrl: three-cycle fetch/decode/execute sequencer with a return-address stack.
module fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              is_halt,
  input  logic              is_ret,
  input  logic              is_call,
  input  logic              is_jmp,
  input  logic              is_jz,
  input  logic              zero_flag,
  input  logic [ADDR_W-1:0] target,
  output logic              ir_load,
  output logic              exec_en,
  output logic              pc_en,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              halted,
  output logic              stack_err,
  output logic [DW-1:0]     depth
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [DW-2:0] idx;
  logic exec, full, empty, do_ret, do_call, do_jmp, do_jz, push, pop, err;
  assign idx = depth[DW-2:0];
  // Priority chain: halt > ret > call > jmp > jz.
  always_comb begin
    exec = state == EXECUTE;
    full = depth == DW'(STACK_DEPTH);
    empty = depth == '0;
    do_ret = !is_halt && is_ret;
    do_call = !is_halt && !is_ret && is_call;
    do_jmp = !is_halt && !is_ret && !is_call && is_jmp;
    do_jz = !is_halt && !is_ret && !is_call && !is_jmp && is_jz;
    push = exec && do_call && !full;
    pop = exec && do_ret && !empty;
    err = exec && ((do_call && full) || (do_ret && empty));
    ir_load = state == FETCH;
    exec_en = exec;
    halted = state == HALT;
    jump_en = push || pop || (exec && (do_jmp || (do_jz && zero_flag)));
    pc_en = exec && !is_halt && !is_ret && !is_call && !is_jmp && !(is_jz && zero_flag);
    jump_addr = !jump_en ? '0 : pop ? stack[idx - 1'b1] : target;
    next = state;
    case (state)
      IDLE:    next = start ? FETCH : IDLE;
      FETCH:   next = DECODE;
      DECODE:  next = EXECUTE;
      EXECUTE: next = (is_halt || err) ? HALT : FETCH;
      default: next = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      depth <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= next;
      if (push) depth <= depth + 1'b1;
      if (pop) depth <= depth - 1'b1;
      if (err) stack_err <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!reset && push) stack[idx] <= pc_in + 1'b1;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a queue-based reference model checked every cycle.
module tb_fetch_ctrl;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] pc_in = 0, target = 0;
  logic is_halt = 0, is_ret = 0, is_call = 0, is_jmp = 0, is_jz = 0, zero_flag = 0;
  logic ir_load, exec_en, pc_en, jump_en, halted, stack_err;
  logic [7:0] jump_addr;
  logic [2:0] depth;
  int total = 0, passed = 0;
  bit chk_on = 0;
  int m_ph = 0;
  bit m_err = 0;
  int m_q[$];

  fetch_ctrl #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
    .is_halt(is_halt), .is_ret(is_ret), .is_call(is_call), .is_jmp(is_jmp), .is_jz(is_jz),
    .zero_flag(zero_flag), .target(target), .ir_load(ir_load), .exec_en(exec_en),
    .pc_en(pc_en), .jump_en(jump_en), .jump_addr(jump_addr), .halted(halted),
    .stack_err(stack_err), .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    else passed++;
  endtask

  // Model: phase 0 idle, 1 fetch, 2 decode, 3 execute, 4 halt; stack is a queue.
  initial forever begin
    int je, ja, pe, nph;
    bit e_push, e_pop, e_err;
    @(negedge clk);
    je = 0; ja = 0; pe = 0; e_push = 0; e_pop = 0; e_err = 0;
    nph = (m_ph == 0) ? (start ? 1 : 0) : (m_ph == 4) ? 4 : (m_ph == 3) ? 1 : m_ph + 1;
    if (m_ph == 3) begin
      if (is_halt) nph = 4;
      else if (is_ret) begin
        if (m_q.size() == 0) begin e_err = 1; nph = 4; end
        else begin je = 1; ja = m_q[$]; e_pop = 1; end
      end else if (is_call) begin
        if (m_q.size() == 4) begin e_err = 1; nph = 4; end
        else begin je = 1; ja = target; e_push = 1; end
      end else if (is_jmp || (is_jz && zero_flag)) begin je = 1; ja = target; end
      else pe = 1;
    end
    if (chk_on) begin
      check("ir_load", ir_load, m_ph == 1);
      check("exec_en", exec_en, m_ph == 3);
      check("halted", halted, m_ph == 4);
      check("pc_en", pc_en, pe);
      check("jump_en", jump_en, je);
      check("jump_addr", jump_addr, ja);
      check("depth", depth, m_q.size());
      check("stack_err", stack_err, m_err);
    end
    if (reset) begin m_ph = 0; m_q.delete(); m_err = 0; end
    else begin
      m_ph = nph;
      if (e_err) m_err = 1;
      if (e_push) m_q.push_back((pc_in + 1) % 256);
      if (e_pop) void'(m_q.pop_back());
    end
  end

  task automatic clear_in();
    {start, is_halt, is_ret, is_call, is_jmp, is_jz, zero_flag} = '0;
    pc_in = 0; target = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    @(posedge clk); #1 reset = 0;
    chk_on = 1;
    check("rst_outs", {ir_load, exec_en, pc_en, jump_en, halted, stack_err}, 0);
    check("rst_addr", jump_addr, 0);
    check("rst_depth", depth, 0);
  endtask

  task automatic go();
    start = 1;
    @(posedge clk); #1 start = 0;
    check("go_fetch", ir_load, 1);
  endtask

  task automatic wait_phase(input int ph, input string n);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (m_ph == ph) break;
    end
    if (m_ph != ph) check({n, "_timeout"}, m_ph, ph);
    @(posedge clk); #1;
  endtask

  task automatic instr(input string n, input logic [4:0] cls, input logic zf,
                       input logic [7:0] tgt, input logic [7:0] pc,
                       input logic eje, input logic [7:0] eja, input logic epe, input logic [2:0] edep);
    {is_halt, is_ret, is_call, is_jmp, is_jz} = cls;
    zero_flag = zf; target = tgt; pc_in = pc;
    wait_phase(3, n);
    check({n, "_je"}, jump_en, eje);
    check({n, "_ja"}, jump_addr, eja);
    check({n, "_pe"}, pc_en, epe);
    check({n, "_ex"}, exec_en, 1);
    @(posedge clk); #1;
    check({n, "_depth"}, depth, edep);
    clear_in();
  endtask

  // cls bit order: halt, ret, call, jmp, jz
  initial begin
    do_reset();
    go();
    instr("seq0", 5'b00000, 0, 0, 0, 0, 0, 1, 0);
    instr("seq1", 5'b00000, 0, 0, 1, 0, 0, 1, 0);
    instr("jmp50", 5'b00010, 0, 50, 2, 1, 50, 0, 0);
    instr("jz_nz", 5'b00001, 0, 60, 3, 0, 0, 1, 0);
    instr("jz_z", 5'b00001, 1, 77, 4, 1, 77, 0, 0);
    instr("call100", 5'b00100, 0, 100, 20, 1, 100, 0, 1);
    instr("ret21", 5'b01000, 0, 0, 100, 1, 21, 0, 0);
    instr("call_wrap", 5'b00100, 0, 10, 255, 1, 10, 0, 1);
    instr("ret_wrap", 5'b01000, 0, 0, 10, 1, 0, 0, 0);
    instr("call_jmp", 5'b00110, 0, 30, 40, 1, 30, 0, 1);
    instr("ret_call", 5'b01100, 1, 99, 30, 1, 41, 0, 0);
    instr("call1", 5'b00100, 0, 9, 1, 1, 9, 0, 1);
    instr("call2", 5'b00100, 0, 9, 2, 1, 9, 0, 2);
    instr("call3", 5'b00100, 0, 9, 3, 1, 9, 0, 3);
    instr("call4", 5'b00100, 0, 9, 4, 1, 9, 0, 4);
    instr("call5", 5'b00100, 0, 9, 5, 0, 0, 0, 4);
    check("ovf_halted", halted, 1);
    check("ovf_err", stack_err, 1);
    start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    check("halt_stays", {halted, ir_load}, 2'b10);
    do_reset();
    go();
    instr("ret_udf", 5'b01000, 0, 0, 7, 0, 0, 0, 0);
    check("udf_halted", halted, 1);
    check("udf_err", stack_err, 1);
    do_reset();
    go();
    instr("callA", 5'b00100, 0, 40, 10, 1, 40, 0, 1);
    instr("callB", 5'b00100, 0, 50, 40, 1, 50, 0, 2);
    is_jmp = 1; target = 8; start = 1;
    wait_phase(2, "to_decode");
    check("in_decode", {ir_load, exec_en}, 0);
    do_reset();
    go();
    instr("halt_jmp", 5'b10010, 0, 33, 5, 0, 0, 0, 0);
    check("hj_halted", halted, 1);
    check("hj_err", stack_err, 0);
    @(negedge clk); #1;
    chk_on = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
